regbank16_rd: RTL

- 16-entry x 16-bit register bank that sits directly upstream of the 16:1 16-bit output mux (mux16_1).
- Holds the 16 register values and drives them in parallel onto the mux data inputs in0..in15.
- Registers each read request into the mux select (sel) and enable (en) inputs, so the mux presents the requested register one cycle after the request.
- Provides one synchronous write port with write-first ordering and an optional hardwired-zero R0, as in MIPS.

---
 rtl/regbank16_rd.sv | 64 ++++++
 1 files changed

// File: rtl/regbank16_rd.sv
// 16 x WIDTH register bank feeding a 16:1 output mux: parallel register outputs,
// registered mux select/enable, one write port with optional hardwired-zero R0.
module regbank16_rd #(
  parameter int WIDTH   = 16,
  parameter int ZERO_R0 = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [3:0]          wr_addr,
  input  logic [WIDTH-1:0]    wr_data,
  input  logic                rd_req,
  input  logic [3:0]          rd_addr,
  output logic [16*WIDTH-1:0] q_all,
  output logic [3:0]          mux_sel,
  output logic                mux_en,
  output logic                wr_ack,
  output logic                wr_drop
);

  logic [WIDTH-1:0] regs [16];
  logic             wr_is_r0_drop;

  assign wr_is_r0_drop = (ZERO_R0 != 0) && (wr_addr == 4'd0);

  // Handshake: wr_en and rd_req are single-cycle valids with no ready; every
  // asserted strobe is accepted on the edge it is sampled. The read result is
  // valid (mux_en) exactly one cycle later; writes are confirmed by wr_ack or
  // rejected by wr_drop in the cycle after the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        regs[i] <= '0;
      end
      mux_sel <= 4'h0;
      mux_en  <= 1'b0;
      wr_ack  <= 1'b0;
      wr_drop <= 1'b0;
    end else begin
      wr_ack  <= 1'b0;
      wr_drop <= 1'b0;
      if (wr_en) begin
        if (wr_is_r0_drop) begin
          wr_drop <= 1'b1;
        end else begin
          regs[wr_addr] <= wr_data;
          wr_ack        <= 1'b1;
        end
      end
      // Write-first falls out naturally: the mux reads q_all after this edge.
      if (rd_req) begin
        mux_sel <= rd_addr;
        mux_en  <= 1'b1;
      end else begin
        mux_en  <= 1'b0;
      end
    end
  end

  for (genvar g = 0; g < 16; g++) begin : g_flat
    assign q_all[WIDTH*g +: WIDTH] = regs[g];
  end

endmodule
